// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Optional feature macro used by the fetch unit: FETCH_BYPASS_EN.
package fetch_pkg;

  localparam int XLEN = 32;

  // Amount the fetch PC advances per issued request (one 32-bit word).
  localparam logic [XLEN-1:0] PC_INC = 32'd4;

  // Mask that forces loaded PCs onto a word boundary.
  localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

  // Fetch sequencing states.
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer with push, pop and flush.
// Push and pop may happen together, including when full; flush wins over both.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          push_eff;
  logic          pop_eff;

  assign empty    = (cnt == '0);
  assign full     = (cnt == CW'(DEPTH));
  assign count    = cnt;
  assign dout     = mem[rd_ptr];
  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign pop_eff  = pop && !empty;
  assign push_eff = push && (!full || pop_eff);

  // Pointer and occupancy bookkeeping; flush empties the buffer at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_eff) wr_ptr <= wr_ptr + AW'(1);
      if (pop_eff)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_eff, pop_eff})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage write; contents are don't-care while the entry is not occupied.
  always_ff @(posedge clk) begin
    if (push_eff && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC sequencing, request throttling, kill of stale
// responses on redirect, and an instruction buffer feeding the decoder.
// Optional macro FETCH_BYPASS_EN: a response arriving into an empty buffer
// while the decoder is ready goes straight to instr (latency 1).
//
// Handshake: instr/instr_pc are stable while instr_valid=1; a transfer occurs
// in any cycle with instr_valid && instr_ready and pops the head. A redirect in
// the same cycle flushes everything, so that word is discarded, not consumed.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic         imem_req,
  output logic [31:0]  imem_addr,
  input  logic [31:0]  imem_rdata,
  input  logic         redirect,
  input  logic [31:0]  redirect_target,
  output logic [31:0]  instr,
  output logic [31:0]  instr_pc,
  output logic         instr_valid,
  input  logic         instr_ready,
  output fetch_state_e state_dbg
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_V = (CW+1)'(FIFO_DEPTH);

  fetch_state_e    state;
  fetch_state_e    state_next;
  logic [XLEN-1:0] pc;
  logic            inflight;
  logic [XLEN-1:0] inflight_pc;
  logic            bypass_take;
  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic [63:0]     fifo_dout;
  logic [CW:0]     occupancy;
  logic            space_ok;
  logic            xfer;

  assign state_dbg = state;
  assign imem_addr = pc;

  // Buffered words plus the one still in flight must fit in the buffer.
  assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
  assign space_ok  = (occupancy < DEPTH_V);
  assign xfer      = instr_valid && instr_ready;

`ifdef FETCH_BYPASS_EN
  assign bypass_take = inflight && fifo_empty && instr_ready;
`else
  assign bypass_take = 1'b0;
`endif

  assign fifo_push = inflight && !bypass_take;
  assign fifo_pop  = instr_ready && !fifo_empty;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (64)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (redirect),
    .din   ({inflight_pc, imem_rdata}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Decoder-facing outputs: buffer head, or the arriving word when bypassing.
  always_comb begin
    instr_valid = !fifo_empty;
    instr       = fifo_empty ? '0 : fifo_dout[31:0];
    instr_pc    = fifo_empty ? '0 : fifo_dout[63:32];
    if (bypass_take) begin
      instr_valid = 1'b1;
      instr       = imem_rdata;
      instr_pc    = inflight_pc;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BOOT;
    else        state <= state_next;
  end

  // Next-state and request generation; a redirect always lands in RUN.
  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    case (state)
      BOOT: state_next = RUN;
      RUN: begin
        if (space_ok) imem_req = 1'b1;
        else          state_next = HOLD;
      end
      HOLD: begin
        if (xfer || space_ok) state_next = RUN;
      end
      default: state_next = BOOT;
    endcase
    if (redirect) state_next = RUN;
  end

  // Fetch PC: redirect loads an aligned target, otherwise advance per request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        pc <= RESET_PC;
    else if (redirect) pc <= redirect_target & ALIGN_MASK;
    else if (imem_req) pc <= pc + PC_INC;
  end

  // In-flight tracking; a request issued during a redirect is killed here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight    <= imem_req && !redirect;
      inflight_pc <= pc;
    end
  end

  // Full flag is implied by occupancy; kept on the sub-module interface only.
  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// run, with a monitor that tracks issued addresses and delivered words
// against a queue of expected PCs.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          FIFO_DEPTH = 4;
`ifdef FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n;
  logic         imem_req;
  logic [31:0]  imem_addr;
  logic [31:0]  imem_rdata;
  logic         redirect;
  logic [31:0]  redirect_target;
  logic [31:0]  instr;
  logic [31:0]  instr_pc;
  logic         instr_valid;
  logic         instr_ready;
  fetch_state_e state_dbg;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  fetch_unit #(
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .state_dbg       (state_dbg)
  );

  // Instruction memory contents as a pure function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h5A3C_96E1;
  endfunction

  // Memory answers one cycle after a request; garbage otherwise.
  always @(posedge clk) begin
    imem_rdata <= imem_req ? mem_word(imem_addr) : $urandom();
  end

  int checks = 0;
  int errors = 0;

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic [31:0] exp_fetch;
  logic        must_req;
  int          xfer_total = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_fetch = RESET_PC;
      must_req  = 1'b0;
    end else begin
      if (instr_valid && !redirect) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL mon_valid_unexpected: instr_valid=1 pc=%h with nothing outstanding", instr_pc);
        end else if (instr_pc !== exp_q[0] || instr !== mem_word(exp_q[0])) begin
          errors++;
          $display("FAIL mon_head: got pc=%h instr=%h, expected pc=%h instr=%h",
                   instr_pc, instr, exp_q[0], mem_word(exp_q[0]));
        end
        if (instr_ready && exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          xfer_total++;
        end
      end
      if (must_req) begin
        checks++;
        if (imem_req !== 1'b1) begin
          errors++;
          $display("FAIL mon_req_after_redirect: imem_req=%b, expected 1", imem_req);
        end
      end
      if (imem_req && !redirect) begin
        checks++;
        if (imem_addr !== exp_fetch) begin
          errors++;
          $display("FAIL mon_addr: imem_addr=%h, expected %h", imem_addr, exp_fetch);
        end
        checks++;
        if (exp_q.size() >= FIFO_DEPTH) begin
          errors++;
          $display("FAIL mon_overrun: request with %0d outstanding, limit %0d", exp_q.size(), FIFO_DEPTH);
        end
        exp_q.push_back(imem_addr);
        exp_fetch = imem_addr + 32'd4;
      end
      must_req = 1'b0;
      if (redirect) begin
        exp_q.delete();
        exp_fetch = redirect_target & 32'hFFFF_FFFC;
        must_req  = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit into the BOOT cycle.
  task automatic do_reset(input logic ready);
    rst_n       = 1'b0;
    redirect    = 1'b0;
    instr_ready = ready;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int req_cyc;
    bit seen;
    rst_n = 1'b0; redirect = 1'b0; redirect_target = '0; instr_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: %b expected 0", imem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: %b expected 0", instr_valid); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: %h expected 0", instr); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset_instr_pc: %h expected 0", instr_pc); end
    checks++; if (state_dbg !== BOOT) begin errors++; $display("FAIL reset_state: %0d expected BOOT", state_dbg); end
    @(posedge clk); #1;
    rst_n = 1'b1; instr_ready = 1'b1;
    @(negedge clk);
    checks++; if (state_dbg !== BOOT || imem_req !== 1'b0) begin
      errors++; $display("FAIL boot_cycle: state=%0d req=%b expected BOOT/0", state_dbg, imem_req);
    end
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      errors++; $display("FAIL first_req: req=%b addr=%h expected 1/%h", imem_req, imem_addr, RESET_PC);
    end
    req_cyc = cyc;
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (instr_valid) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL first_valid_timeout: no instr_valid within 8 cycles");
    end else if (cyc - req_cyc != LAT || instr_pc !== RESET_PC) begin
      errors++; $display("FAIL first_latency: latency=%0d pc=%h expected %0d/%h", cyc - req_cyc, instr_pc, LAT, RESET_PC);
    end
  endtask

  task automatic test_throughput();
    int n;
    instr_ready = 1'b1;
    repeat (4) tick();
    n = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (instr_valid && instr_ready) n++;
    end
    checks++;
    if (n != 16) begin errors++; $display("FAIL throughput: %0d transfers in 16 cycles, expected 16", n); end
  endtask

  task automatic test_hold();
    int n;
    do_reset(1'b0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (imem_req) n++;
    end
    checks++; if (n != 4) begin errors++; $display("FAIL hold_req_count: %0d requests, expected 4", n); end
    checks++; if (imem_req !== 1'b0 || state_dbg !== HOLD) begin
      errors++; $display("FAIL hold_state: req=%b state=%0d expected 0/HOLD", imem_req, state_dbg);
    end
    tick();
    instr_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC + 32'h10) begin
      errors++; $display("FAIL hold_resume: req=%b addr=%h expected 1/%h", imem_req, imem_addr, RESET_PC + 32'h10);
    end
    repeat (12) tick();
  endtask

  task automatic test_redirect();
    bit seen;
    do_reset(1'b0);
    repeat (5) tick();
    redirect = 1'b1; redirect_target = 32'h0000_0100;
    @(negedge clk);
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL redir_pre_valid: %b expected 1", instr_valid); end
    tick();
    redirect = 1'b0; instr_ready = 1'b1;
    @(negedge clk);
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_flush: instr_valid=%b expected 0", instr_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      errors++; $display("FAIL redir_addr: req=%b addr=%h expected 1/00000100", imem_req, imem_addr);
    end
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      if (instr_valid && instr_ready) seen = 1;
      else @(negedge clk);
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL redir_first_timeout: no transfer within 8 cycles"); end
    else if (instr_pc !== 32'h100 || instr !== mem_word(32'h100)) begin
      errors++; $display("FAIL redir_first_pc: pc=%h instr=%h expected 00000100/%h", instr_pc, instr, mem_word(32'h100));
    end
    repeat (6) tick();
  endtask

  task automatic test_back_to_back();
    bit first;
    instr_ready = 1'b1;
    tick();
    redirect = 1'b1; redirect_target = 32'h0000_0200;
    tick();
    redirect_target = 32'h0000_0300;
    tick();
    redirect = 1'b0;
    first = 1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (instr_valid && instr_ready) begin
        checks++;
        if (instr_pc >= 32'h200 && instr_pc < 32'h300) begin
          errors++; $display("FAIL b2b_stale: pc=%h from first target reached decoder", instr_pc);
        end
        if (first) begin
          checks++;
          if (instr_pc !== 32'h300) begin errors++; $display("FAIL b2b_first: pc=%h expected 00000300", instr_pc); end
          first = 0;
        end
      end
    end
    checks++; if (first) begin errors++; $display("FAIL b2b_timeout: no transfer after redirects"); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_a [3];
    exp_a[0] = 32'hFFFF_FFF8; exp_a[1] = 32'hFFFF_FFFC; exp_a[2] = 32'h0000_0000;
    instr_ready = 1'b1;
    tick();
    redirect = 1'b1; redirect_target = 32'hFFFF_FFFA;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== exp_a[i]) begin
        errors++; $display("FAIL wrap_addr%0d: req=%b addr=%h expected 1/%h", i, imem_req, imem_addr, exp_a[i]);
      end
    end
    repeat (8) tick();
  endtask

  task automatic test_reset_midstream();
    instr_ready = 1'b0;
    repeat (8) tick();
    @(negedge clk);
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL mid_full_valid: %b expected 1", instr_valid); end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin
      errors++; $display("FAIL mid_reset_clear: valid=%b req=%b expected 0/0", instr_valid, imem_req);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1; instr_ready = 1'b1;
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL mid_boot_req: %b expected 0", imem_req); end
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      errors++; $display("FAIL mid_restart: req=%b addr=%h expected 1/%h", imem_req, imem_addr, RESET_PC);
    end
    repeat (8) tick();
  endtask

  task automatic test_random();
    int start_x;
    start_x = xfer_total;
    for (int i = 0; i < 600; i++) begin
      tick();
      instr_ready = ($urandom_range(0, 9) < 7);
      redirect    = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 3) == 0) redirect_target = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else                           redirect_target = $urandom();
    end
    tick();
    redirect = 1'b0; instr_ready = 1'b1;
    repeat (12) tick();
    checks++;
    if (xfer_total - start_x < 200) begin
      errors++; $display("FAIL rand_progress: %0d transfers, expected at least 200", xfer_total - start_x);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_throughput();
    test_hold();
    test_redirect();
    test_back_to_back();
    test_wrap();
    test_reset_midstream();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
